radix8_booth_seq_mult: RTL and testbench

// - Complete sequential radix-8 Booth multiplier: K-bit x (multiplier) by K-bit a (multiplicand), giving a 2K-bit product.
// - Successor to the fixed-width Booth forming logic; adds a parametrised width, a signed/unsigned mode,
//   an internal accumulator, an FSM and a start/busy/done handshake.
// - Sits behind the datapath issue logic as a multi-cycle arithmetic unit; retires one 3-bit Booth group per cycle.

---
 rtl/radix8_booth_seq_mult.sv | 127 ++++++++++++
 tb/tb_radix8_booth_seq_mult.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/radix8_booth_seq_mult.sv
// Sequential radix-8 Booth multiplier: one Booth group per cycle behind a start/busy/done handshake.
// Optional early exit when the remaining Booth digits are all zero: define BOOTH8_EARLY_TERM_EN.
module radix8_booth_seq_mult #(
  parameter int unsigned K = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           tc,
  input  logic [K-1:0]   x,
  input  logic [K-1:0]   a,
  output logic [2*K-1:0] product,
  output logic           busy,
  output logic           done
);

  localparam int unsigned ITER = (K + 1 + 2) / 3;
  localparam int unsigned XW   = 3 * ITER;
  localparam int unsigned HW   = K + 5;
  localparam int unsigned FW   = HW + XW;
  localparam int unsigned PW   = 2 * K;
  localparam int unsigned CW   = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PRECOMP, S_ITER, S_DONE} state_t;

  state_t        state;
  logic [HW-1:0] acc;
  logic [XW-1:0] mq;
  logic          xm1;
  logic [HW-1:0] a1;
  logic [HW-1:0] a3;
  logic [CW-1:0] cnt;

  logic [3:0]    grp_c;
  logic          neg_c;
  logic [HW-1:0] pp_c;
  logic [HW-1:0] sum_c;
  logic [FW-1:0] full_c;
  logic          last_c;
  logic          finish_c;
  logic [PW-1:0] prod_c;

  // Booth digit select, accumulate, and the combined {acc, mq} arithmetic shift by 3
  always_comb begin
    grp_c = {mq[2:0], xm1};
    pp_c  = '0;
    case (grp_c)
      4'b0001, 4'b0010, 4'b1101, 4'b1110: pp_c = a1;
      4'b0011, 4'b0100, 4'b1011, 4'b1100: pp_c = a1 << 1;
      4'b0101, 4'b0110, 4'b1001, 4'b1010: pp_c = a3;
      4'b0111, 4'b1000:                   pp_c = a1 << 2;
      default:                            pp_c = '0;
    endcase
    neg_c  = grp_c[3] & ~(&grp_c[2:0]);
    sum_c  = acc + (neg_c ? ~pp_c : pp_c) + HW'(neg_c);
    full_c = {{3{sum_c[HW-1]}}, sum_c, mq[XW-1:3]};
    last_c = (cnt == CW'(ITER - 1));
  end

`ifdef BOOTH8_EARLY_TERM_EN
  int            rem_c;
  logic [XW-1:0] mask_c;
  logic          rest_zero_c;

  // Remaining groups are all-zero digits when the unconsumed bits match the held bit;
  // the skipped shifts collapse into one arithmetic shift of the partial result.
  always_comb begin
    rem_c       = 3 * (int'(ITER) - 1 - int'(cnt));
    mask_c      = ~({XW{1'b1}} << rem_c);
    rest_zero_c = (((full_c[XW-1:0] ^ {XW{mq[2]}}) & mask_c) == '0);
    finish_c    = last_c | rest_zero_c;
    prod_c      = PW'($signed(full_c) >>> rem_c);
  end
`else
  assign finish_c = last_c;
  assign prod_c   = full_c[PW-1:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      acc     <= '0;
      mq      <= '0;
      xm1     <= 1'b0;
      a1      <= '0;
      a3      <= '0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a1    <= {{(HW-K){tc & a[K-1]}}, a};
            mq    <= {{(XW-K){tc & x[K-1]}}, x};
            xm1   <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_PRECOMP;
          end
        end
        S_PRECOMP: begin
          a3    <= a1 + (a1 << 1);
          state <= S_ITER;
        end
        S_ITER: begin
          acc <= full_c[FW-1:XW];
          mq  <= full_c[XW-1:0];
          xm1 <= mq[2];
          cnt <= cnt + CW'(1);
          if (finish_c) begin
            product <= prod_c;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_radix8_booth_seq_mult.sv
// Directed bench for radix8_booth_seq_mult (K=8): vector table plus handshake/reset corner sequences.
module tb_radix8_booth_seq_mult;

  localparam int unsigned K = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           tc;
  logic [K-1:0]   x;
  logic [K-1:0]   a;
  logic [2*K-1:0] product;
  logic           busy;
  logic           done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  radix8_booth_seq_mult #(.K(K)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .tc      (tc),
    .x       (x),
    .a       (a),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  typedef struct {
    logic       t;
    logic [7:0] xv;
    logic [7:0] av;
    logic [15:0] p;
    int         lat_early;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one operation and report the cycle (after the accept edge) in which done appears.
  task automatic run_op(input logic t, input logic [7:0] xv, input logic [7:0] av,
                        output logic [15:0] p, output int lat, output logic b1);
    @(negedge clk);
    tc = t; x = xv; a = av; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    b1  = busy;
    lat = -1;
    p   = '0;
    for (int c = 1; c <= 20; c++) begin
      if (done) begin
        lat = c;
        p   = product;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [15:0] p;
    int          lat;
    int          exp_lat;
    logic        b1;
    logic        seen;

    tbl[0]  = '{1'b1, 8'h80, 8'h80, 16'h4000, 5};
    tbl[1]  = '{1'b1, 8'h7F, 8'hFF, 16'hFF81, 5};
    tbl[2]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 5};
    tbl[3]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001, 3};
    tbl[4]  = '{1'b0, 8'h03, 8'h05, 16'h000F, 3};
    tbl[5]  = '{1'b0, 8'h1C, 8'h7F, 16'h0DE4, 4};
    tbl[6]  = '{1'b0, 8'h01, 8'h09, 16'h0009, 3};
    tbl[7]  = '{1'b1, 8'hFF, 8'h07, 16'hFFF9, 3};
    tbl[8]  = '{1'b0, 8'h00, 8'h55, 16'h0000, 3};
    tbl[9]  = '{1'b1, 8'h7F, 8'h7F, 16'h3F01, 5};
    tbl[10] = '{1'b1, 8'h80, 8'h7F, 16'hC080, 5};
    tbl[11] = '{1'b0, 8'h80, 8'hFF, 16'h7F80, 5};
    tbl[12] = '{1'b1, 8'hF9, 8'h06, 16'hFFD6, 4};

    rst = 1'b0; start = 1'b0; tc = 1'b0; x = '0; a = '0;
    #12;
    check("reset product", 32'(product), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset done", 32'(done), 32'h0);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
`ifdef BOOTH8_EARLY_TERM_EN
      exp_lat = tbl[i].lat_early;
`else
      exp_lat = 5;
`endif
      run_op(tbl[i].t, tbl[i].xv, tbl[i].av, p, lat, b1);
      check($sformatf("vec%0d product", i), 32'(p), 32'(tbl[i].p));
      check($sformatf("vec%0d done cycle", i), 32'(lat), 32'(exp_lat));
      check($sformatf("vec%0d busy cycle1", i), 32'(b1), 32'h1);
      @(posedge clk); #1;
    end

    // start re-pulsed with new operands in cycles 2..4 must be ignored
    @(negedge clk);
    tc = 1'b1; x = 8'h80; a = 8'h80; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; tc = 1'b0; x = 8'h55; a = 8'h66;
    @(posedge clk); #1;
    check("repulse done c3", 32'(done), 32'h0);
    @(posedge clk); #1;
    check("repulse done c4", 32'(done), 32'h0);
    @(posedge clk); #1 start = 1'b0;
    check("repulse done c5", 32'(done), 32'h1);
    check("repulse product", 32'(product), 32'h4000);
    check("repulse busy c5", 32'(busy), 32'h0);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (busy || done) seen = 1'b1;
    end
    check("repulse no relaunch", 32'(seen), 32'h0);
    check("repulse product held", 32'(product), 32'h4000);

    // reset in cycle 3 of an operation
    @(negedge clk);
    tc = 1'b1; x = 8'h7F; a = 8'h7F; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midop busy before reset", 32'(busy), 32'h1);
    rst = 1'b0;
    #1;
    check("midop reset product", 32'(product), 32'h0);
    check("midop reset busy", 32'(busy), 32'h0);
    check("midop reset done", 32'(done), 32'h0);
    @(negedge clk); rst = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (busy || done) seen = 1'b1;
    end
    check("midop no done after reset", 32'(seen), 32'h0);

    // start held high: DONE cycle ignores it, IDLE accepts on the next edge
    @(negedge clk);
    tc = 1'b1; x = 8'h7F; a = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    check("b2b first done", 32'(done), 32'h1);
    check("b2b first product", 32'(product), 32'hFF81);
    x = 8'h7F; a = 8'h7F;
    @(posedge clk); #1;
    check("b2b idle busy", 32'(busy), 32'h0);
    check("b2b idle done", 32'(done), 32'h0);
    @(posedge clk); #1 start = 1'b0;
    check("b2b second busy", 32'(busy), 32'h1);
    check("b2b product held c1", 32'(product), 32'hFF81);
    repeat (3) @(posedge clk);
    #1;
    check("b2b product held c4", 32'(product), 32'hFF81);
    check("b2b done early", 32'(done), 32'h0);
    @(posedge clk); #1;
    check("b2b second done", 32'(done), 32'h1);
    check("b2b second product", 32'(product), 32'h3F01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
